// File: rtl/trace_cmd_sequencer.sv
// Trace command sequencer: buffers parsed trace records in order, issues each one on
// the L1 or snoop request channel, and ends the run with a single "PS" request.
module trace_cmd_sequencer #(
  parameter int ADDR_W = 32,
  parameter int CMD_W  = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_valid,
  input  logic [CMD_W-1:0]  rec_cmd,
  input  logic [ADDR_W-1:0] rec_addr,
  input  logic              rec_last,
  output logic              rec_ready,
  output logic              l1_valid,
  output logic [15:0]       l1_op,
  output logic [ADDR_W-1:0] l1_addr,
  input  logic              l1_ready,
  output logic              snp_valid,
  output logic [7:0]        snp_op,
  output logic [ADDR_W-1:0] snp_addr,
  input  logic              snp_ready,
  output logic [CNT_W-1:0]  l1_cnt,
  output logic [CNT_W-1:0]  snp_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              busy,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = CMD_W + ADDR_W;
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  localparam logic [15:0] OP_DR = "DR";
  localparam logic [15:0] OP_DW = "DW";
  localparam logic [15:0] OP_IR = "IR";
  localparam logic [15:0] OP_CL = "CL";
  localparam logic [15:0] OP_PR = "PR";
  localparam logic [15:0] OP_PS = "PS";
  localparam logic [7:0]  OP_I  = "I";
  localparam logic [7:0]  OP_R  = "R";
  localparam logic [7:0]  OP_W  = "W";
  localparam logic [7:0]  OP_M  = "M";

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ISSUE_L1,
    ISSUE_SNP,
    STATS,
    DONE
  } state_t;

  state_t state_reg;

  logic [RW-1:0]     mem [DEPTH];
  logic [AW:0]       wr_ptr_reg;
  logic [AW:0]       rd_ptr_reg;
  logic              last_seen_reg;
  logic              ready_en_reg;

  logic [AW:0]       fill_w;
  logic              empty_w;
  logic              full_w;
  logic              push_w;
  logic              pop_w;
  logic [CMD_W-1:0]  head_cmd;
  logic [ADDR_W-1:0] head_addr;

  logic              dec_l1;
  logic              dec_snp;
  logic [15:0]       dec_l1_op;
  logic [7:0]        dec_snp_op;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fill_w  = wr_ptr_reg - rd_ptr_reg;
  assign empty_w = (wr_ptr_reg == rd_ptr_reg);
  assign full_w  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign rec_ready = ready_en_reg && !full_w && !last_seen_reg;
  assign push_w    = rec_valid && rec_ready;
  assign pop_w     = (state_reg == FETCH) && !empty_w;
  assign busy      = !empty_w || ((state_reg != IDLE) && (state_reg != DONE));

  always_ff @(posedge clk) begin
    if (push_w) begin
      mem[wr_ptr_reg[AW-1:0]] <= {rec_cmd, rec_addr};
    end
  end

  assign {head_cmd, head_addr} = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_w) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop_w) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

  always_comb begin
    dec_l1     = 1'b0;
    dec_snp    = 1'b0;
    dec_l1_op  = '0;
    dec_snp_op = '0;
    case (head_cmd)
      CMD_W'(0): begin dec_l1  = 1'b1; dec_l1_op  = OP_DR; end
      CMD_W'(1): begin dec_l1  = 1'b1; dec_l1_op  = OP_DW; end
      CMD_W'(2): begin dec_l1  = 1'b1; dec_l1_op  = OP_IR; end
      CMD_W'(8): begin dec_l1  = 1'b1; dec_l1_op  = OP_CL; end
      CMD_W'(9): begin dec_l1  = 1'b1; dec_l1_op  = OP_PR; end
      CMD_W'(3): begin dec_snp = 1'b1; dec_snp_op = OP_I;  end
      CMD_W'(4): begin dec_snp = 1'b1; dec_snp_op = OP_R;  end
      CMD_W'(5): begin dec_snp = 1'b1; dec_snp_op = OP_W;  end
      CMD_W'(6): begin dec_snp = 1'b1; dec_snp_op = OP_M;  end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      last_seen_reg <= 1'b0;
      ready_en_reg  <= 1'b0;
      l1_valid      <= 1'b0;
      l1_op         <= '0;
      l1_addr       <= '0;
      snp_valid     <= 1'b0;
      snp_op        <= '0;
      snp_addr      <= '0;
      l1_cnt        <= '0;
      snp_cnt       <= '0;
      err_cnt       <= '0;
      done          <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push_w && rec_last) begin
        last_seen_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          // Leave on the accepting edge so a new record issues two cycles after it arrives.
          if (!empty_w || push_w) begin
            state_reg <= FETCH;
          end else if (last_seen_reg) begin
            state_reg <= STATS;
            l1_valid  <= 1'b1;
            l1_op     <= OP_PS;
            l1_addr   <= '0;
          end
        end

        FETCH: begin
          if (!empty_w) begin
            if (dec_l1) begin
              state_reg <= ISSUE_L1;
              l1_valid  <= 1'b1;
              l1_op     <= dec_l1_op;
              l1_addr   <= head_addr;
            end else if (dec_snp) begin
              state_reg <= ISSUE_SNP;
              snp_valid <= 1'b1;
              snp_op    <= dec_snp_op;
              snp_addr  <= head_addr;
            end else begin
              err_cnt   <= sat_inc(err_cnt);
              state_reg <= ((fill_w > PTR_ONE) || push_w) ? FETCH : IDLE;
            end
          end else if (last_seen_reg) begin
            state_reg <= STATS;
            l1_valid  <= 1'b1;
            l1_op     <= OP_PS;
            l1_addr   <= '0;
          end else begin
            state_reg <= IDLE;
          end
        end

        ISSUE_L1: begin
          if (l1_ready) begin
            state_reg <= FETCH;
            l1_valid  <= 1'b0;
            l1_op     <= '0;
            l1_addr   <= '0;
            l1_cnt    <= sat_inc(l1_cnt);
          end
        end

        ISSUE_SNP: begin
          if (snp_ready) begin
            state_reg <= FETCH;
            snp_valid <= 1'b0;
            snp_op    <= '0;
            snp_addr  <= '0;
            snp_cnt   <= sat_inc(snp_cnt);
          end
        end

        STATS: begin
          if (l1_ready) begin
            state_reg <= DONE;
            l1_valid  <= 1'b0;
            l1_op     <= '0;
            l1_addr   <= '0;
            done      <= 1'b1;
          end
        end

        DONE: begin
          done <= 1'b1;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/trace_cmd_sequencer.md
Name: trace_cmd_sequencer

Overview:
- Clocked, parametrised successor to the trace-driven bus stimulus path.
- Accepts parsed trace records (command, address) over a valid/ready handshake and buffers them in an in-order FIFO.
- Decodes each record and issues it on the L1 request channel or the snoop channel, each with its own valid/ready handshake.
- Drops and counts illegal commands, keeps per-channel issue counters, and issues a final print-stats ("PS") request after the last record drains.

Parameters:
- ADDR_W, 32, address width of records and both output channels.
- CMD_W, 4, trace command field width.
- DEPTH, 8, record FIFO depth; power of 2, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rec_valid  input  1  trace record present.
- rec_cmd  input  CMD_W  trace command code.
- rec_addr  input  ADDR_W  trace address.
- rec_last  input  1  qualifies the accepted record as the final trace record.
- rec_ready  output  1  sequencer can accept a record.
- l1_valid  output  1  L1 request valid.
- l1_op  output  16  ASCII op: "DR", "DW", "IR", "CL", "PR" or "PS".
- l1_addr  output  ADDR_W  L1 request address.
- l1_ready  input  1  L1 consumer accepts.
- snp_valid  output  1  snoop request valid.
- snp_op  output  8  ASCII op: "I", "R", "W" or "M".
- snp_addr  output  ADDR_W  snoop address.
- snp_ready  input  1  snoop consumer accepts.
- l1_cnt  output  CNT_W  L1 requests issued, excluding PS.
- snp_cnt  output  CNT_W  snoop requests issued.
- err_cnt  output  CNT_W  illegal commands dropped.
- busy  output  1  FIFO non-empty or FSM not in IDLE/DONE.
- done  output  1  PS handshake completed.

Behaviour:
- Clock and reset:
  - One clock; reset is asynchronous and active-low.
  - Asserting rst_n=0 at any time, including mid-handshake, empties the FIFO, clears last_seen, forces FSM to IDLE, zeroes all counters, and drives every output to 0.
  - rec_ready is 0 while reset is asserted and becomes 1 on the first clock after deassertion.
- Record input:
  - A record is accepted on a rising edge with rec_valid && rec_ready.
  - rec_ready = !full && !last_seen; it is derived from registered state only.
  - Accepting a record with rec_last=1 sets last_seen. No further records are accepted until reset.
  - Push and pop in the same cycle are legal whenever not full; occupancy is then unchanged.
  - Pointers wrap modulo DEPTH.
- Command decode:
  - 0 -> L1 "DR"; 1 -> "DW"; 2 -> "IR"; 8 -> "CL"; 9 -> "PR".
  - 3 -> snoop "I"; 4 -> "R"; 5 -> "W"; 6 -> "M".
  - Any other code (7, 10-15) is illegal: dropped, err_cnt+1, nothing issued.
- FSM states:
  - IDLE: go to FETCH when the FIFO is non-empty.
  - FETCH: pop the head into holding registers, then go to ISSUE_L1 or ISSUE_SNP by decode. Illegal: stay in FETCH if the FIFO is still non-empty, else IDLE. FIFO empty and last_seen: go to STATS.
  - ISSUE_L1 / ISSUE_SNP: hold valid, op and addr stable until ready. On the handshake edge, increment the channel counter and go to FETCH.
  - STATS: l1_valid=1, l1_op="PS", l1_addr=0. On handshake go to DONE.
  - DONE: done=1; all valids 0; held until reset.
  - From IDLE with last_seen and the FIFO empty, go to STATS.
- Timing:
  - A record accepted at edge N gives valid asserted in the cycle after edge N+1: two cycles of latency with ready held high.
  - Peak throughput is one record per 2 cycles.
  - A ready that is high before valid completes the handshake on the first valid edge.
  - Only one channel is valid at a time; issue order strictly follows trace order.
- Idle values: when a channel's valid is 0, its op and addr are driven 0 (never Z).
- Counters saturate at 2^CNT_W-1; they do not wrap.
- The CL command does not clear counters or FIFO contents.

Test Plan:
- Reset mid-issue: rst_n low while l1_valid=1 (l1_ready=0) -> all outputs 0, FIFO empty; a new record issues correctly after release.
- Single record: push cmd=0, addr=0x0000_1234, rec_last=1, ready tied high -> l1_valid 2 cycles after accept with op "DR", addr 0x1234; then PS with addr 0; done=1, l1_cnt=1.
- Backpressure/order: push cmds 4, 1, 6 with snp_ready=0 for 10 cycles -> snp_valid/"R" held stable for 10 cycles, then "DW" on L1, then "M" on snoop, in order; snp_cnt=2, l1_cnt=1.
- Full FIFO: push DEPTH+2 records with both readys low -> rec_ready drops after DEPTH+1 accepts (DEPTH in FIFO + 1 in holding register); no record lost or duplicated after release.
- Illegal codes: push 7, 12, 2 -> err_cnt=2, single "IR" issued, no snoop activity.
- Saturation: CNT_W=4, 20 snoop records -> snp_cnt sticks at 15.
